// File: rtl/unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module : unpack_pkg
// Brief  : Shared constants and state encoding for the word-to-byte unpacker.
// Rev    : 1.0 - initial release
// ============================================================================
package unpack_pkg;

  // Default output byte width in bits
  localparam int unsigned c_default_w = 8;

  // EMPTY: no word held; SEND: word held, bytes being emitted
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/unpack_if.sv
`default_nettype none
// ============================================================================
// Module : unpack_if
// Brief  : Stream bundle for the unpacker: wide input word channel (s_*) and
//          narrow output byte channel (m_*), both strobe/ready handshakes.
//          The slave modport is the unpacker's own view; the master modport
//          is the view of the logic surrounding it.
// Rev    : 1.0 - initial release
// ============================================================================
interface unpack_if
  import unpack_pkg::*;
#(
  parameter int unsigned W = c_default_w,
  parameter int unsigned N = 2
);

  logic           s_stb;
  logic [N*W-1:0] s_dat;
  logic           s_rdy;
  logic           m_stb;
  logic [W-1:0]   m_dat;
  logic           m_rdy;

  modport slave (
    input  s_stb,
    input  s_dat,
    output s_rdy,
    output m_stb,
    output m_dat,
    input  m_rdy
  );

  modport master (
    output s_stb,
    output s_dat,
    input  s_rdy,
    input  m_stb,
    input  m_dat,
    output m_rdy
  );

endinterface
`default_nettype wire

// File: rtl/unpack.sv
`default_nettype none
// ============================================================================
// Module : unpack
// Brief  : Splits N*W-bit input words into N consecutive W-bit output bytes.
//          One byte per clock at full throughput; a new word is accepted in
//          the same cycle the last byte of the previous word leaves.
//          Build option UNPACK_MSB_FIRST_EN: emit most significant byte first
//          (default build emits least significant byte first).
// Rev    : 1.0 - initial release
// ============================================================================
module unpack
  import unpack_pkg::*;
#(
  parameter int unsigned W = c_default_w,
  parameter int unsigned N = 2
) (
  input  logic   clk,
  input  logic   rst,
  unpack_if.slave bus
);

  localparam int unsigned     c_iw   = (N > 1) ? $clog2(N) : 1;
  localparam logic [c_iw-1:0] c_last = c_iw'(N - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_iw-1:0] r_idx;
  logic [c_iw-1:0] w_idx_nxt;
  logic [N*W-1:0]  r_hold;
  logic            w_load;
  logic            w_last;
  logic            w_s_rdy;
  logic            w_m_stb;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic [W-1:0]    w_bytes [N];

  // Holding register lanes, ordered by emission index
  for (genvar i = 0; i < N; i++) begin : g_lane
`ifdef UNPACK_MSB_FIRST_EN
    assign w_bytes[i] = r_hold[(N-1-i)*W +: W];
`else
    assign w_bytes[i] = r_hold[i*W +: W];
`endif
  end

  assign w_last     = (r_idx == c_last);
  // Ready while empty, or while the last byte is leaving this very cycle
  assign w_s_rdy    = (r_state == EMPTY) | (w_last & bus.m_rdy);
  assign w_m_stb    = (r_state == SEND);
  assign w_in_xfer  = bus.s_stb & w_s_rdy;
  assign w_out_xfer = w_m_stb & bus.m_rdy;

  assign bus.s_rdy  = w_s_rdy;
  assign bus.m_stb  = w_m_stb;
  assign bus.m_dat  = w_m_stb ? w_bytes[r_idx] : '0;

  // Next-state, next-index and word-capture decisions
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = SEND;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (w_out_xfer) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + c_iw'(1);
          end else if (w_in_xfer) begin
            w_state_nxt = SEND;
            w_idx_nxt   = '0;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = EMPTY;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State and byte index registers; reset discards any partial word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Word holding register, written only on an accepted input word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_load) begin
      r_hold <= bus.s_dat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unpack.sv
`default_nettype none
// ============================================================================
// Module : tb_unpack
// Brief  : Self-checking bench for unpack (N=2 and N=4 instances). Expected
//          byte order follows UNPACK_MSB_FIRST_EN when defined.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_unpack;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  unpack_if #(.W(8), .N(2)) b2 ();
  unpack_if #(.W(8), .N(4)) b4 ();

  unpack #(.W(8), .N(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  unpack #(.W(8), .N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  // Byte k (emission order) of an n-byte word
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int k, input int n);
`ifdef UNPACK_MSB_FIRST_EN
    return w[(n-1-k)*8 +: 8];
`else
    return w[k*8 +: 8];
`endif
  endfunction

  function automatic logic [7:0] b(input logic [15:0] w, input int k);
    return byte_at({16'h0000, w}, k, 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic        stb;
    logic [15:0] dat;
    logic        mrdy;
    logic        e_mstb;
    logic [7:0]  e_mdat;
    logic        e_srdy;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic stb, input logic [15:0] dat, input logic mrdy,
                              input logic e_mstb, input logic [7:0] e_mdat, input logic e_srdy);
    vec_t v;
    v.stb = stb; v.dat = dat; v.mrdy = mrdy;
    v.e_mstb = e_mstb; v.e_mdat = e_mdat; v.e_srdy = e_srdy;
    vt.push_back(v);
  endfunction

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  exp_b;
    logic [7:0]  prev_dat;
    logic        prev_stall;
    int          words_in;
    int          bytes_out;
    int          cyc;

    b2.s_stb = 1'b0; b2.s_dat = '0; b2.m_rdy = 1'b0;
    b4.s_stb = 1'b0; b4.s_dat = '0; b4.m_rdy = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mstb2", b2.m_stb, 1'b0);
    chk("rst_mdat2", b2.m_dat, 8'h00);
    chk("rst_srdy2", b2.s_rdy, 1'b1);
    chk("rst_mstb4", b4.m_stb, 1'b0);
    chk("rst_srdy4", b4.s_rdy, 1'b1);
    rst = 1'b0;

    // Per-cycle vectors: inputs applied, outputs expected in the same cycle
    add(1, 16'hA55A, 1, 0, 8'h00,           1);
    add(0, 16'h0000, 1, 1, b(16'hA55A, 0),  0);
    add(0, 16'h0000, 1, 1, b(16'hA55A, 1),  1);
    add(0, 16'h0000, 1, 0, 8'h00,           1);
    add(1, 16'h0102, 1, 0, 8'h00,           1);
    add(1, 16'h0304, 1, 1, b(16'h0102, 0),  0);
    add(1, 16'h0304, 1, 1, b(16'h0102, 1),  1);
    add(1, 16'h0506, 1, 1, b(16'h0304, 0),  0);
    add(1, 16'h0506, 1, 1, b(16'h0304, 1),  1);
    add(0, 16'h0000, 1, 1, b(16'h0506, 0),  0);
    add(0, 16'h0000, 1, 1, b(16'h0506, 1),  1);
    add(0, 16'h0000, 1, 0, 8'h00,           1);
    add(1, 16'hBEEF, 0, 0, 8'h00,           1);
    for (int i = 0; i < 5; i++) add(1, 16'h1111, 0, 1, b(16'hBEEF, 0), 0);
    add(0, 16'h0000, 1, 1, b(16'hBEEF, 0),  0);
    add(0, 16'h0000, 1, 1, b(16'hBEEF, 1),  1);
    add(0, 16'h0000, 1, 0, 8'h00,           1);
    add(1, 16'h0A0B, 1, 0, 8'h00,           1);
    add(0, 16'h0000, 1, 1, b(16'h0A0B, 0),  0);
    add(1, 16'hCCDD, 0, 1, b(16'h0A0B, 1),  0);
    add(0, 16'h0000, 1, 1, b(16'h0A0B, 1),  1);
    add(0, 16'h0000, 1, 0, 8'h00,           1);

    foreach (vt[i]) begin
      @(posedge clk);
      #1;
      b2.s_stb = vt[i].stb;
      b2.s_dat = vt[i].dat;
      b2.m_rdy = vt[i].mrdy;
      #1;
      chk($sformatf("vec%0d_mstb", i), b2.m_stb, vt[i].e_mstb);
      if (vt[i].e_mstb) chk($sformatf("vec%0d_mdat", i), b2.m_dat, vt[i].e_mdat);
      chk($sformatf("vec%0d_srdy", i), b2.s_rdy, vt[i].e_srdy);
    end

    // Reset in the middle of a word
    @(posedge clk); #1;
    b2.s_stb = 1'b1; b2.s_dat = 16'h1234; b2.m_rdy = 1'b1;
    @(posedge clk); #1;
    b2.s_stb = 1'b0;
    #1;
    chk("mid_first_stb", b2.m_stb, 1'b1);
    chk("mid_first_dat", b2.m_dat, b(16'h1234, 0));
    @(posedge clk); #1;
    chk("mid_second_dat", b2.m_dat, b(16'h1234, 1));
    rst = 1'b1;
    #1;
    chk("mid_rst_mstb", b2.m_stb, 1'b0);
    chk("mid_rst_mdat", b2.m_dat, 8'h00);
    chk("mid_rst_srdy", b2.s_rdy, 1'b1);
    @(posedge clk); #1;
    chk("mid_rst_hold_mstb", b2.m_stb, 1'b0);
    rst = 1'b0;
    b2.s_stb = 1'b1; b2.s_dat = 16'h5678;
    #1;
    chk("post_rst_srdy", b2.s_rdy, 1'b1);
    @(posedge clk); #1;
    b2.s_stb = 1'b0;
    #1;
    chk("post_rst_b0_stb", b2.m_stb, 1'b1);
    chk("post_rst_b0_dat", b2.m_dat, b(16'h5678, 0));
    @(posedge clk); #1;
    chk("post_rst_b1_stb", b2.m_stb, 1'b1);
    chk("post_rst_b1_dat", b2.m_dat, b(16'h5678, 1));
    @(posedge clk); #1;
    chk("post_rst_end_stb", b2.m_stb, 1'b0);

    // N=4 single word at full rate
    b4.s_stb = 1'b1; b4.s_dat = 32'hDEADBEEF; b4.m_rdy = 1'b1;
    #1;
    chk("n4_srdy", b4.s_rdy, 1'b1);
    @(posedge clk); #1;
    b4.s_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("n4_b%0d_stb", k), b4.m_stb, 1'b1);
      chk($sformatf("n4_b%0d_dat", k), b4.m_dat, byte_at(32'hDEADBEEF, k, 4));
      @(posedge clk); #1;
    end
    chk("n4_end_stb", b4.m_stb, 1'b0);

    // N=4 random handshakes against a byte scoreboard
    words_in   = 0;
    bytes_out  = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_dat   = '0;
    while ((words_in < 1000 || q.size() != 0) && cyc < 30000) begin
      @(posedge clk); #1;
      if (prev_stall) begin
        chk("sb_hold_stb", b4.m_stb, 1'b1);
        chk("sb_hold_dat", b4.m_dat, prev_dat);
      end
      b4.s_stb = (words_in < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      b4.s_dat = $urandom();
      b4.m_rdy = ($urandom_range(0, 2) != 0);
      #1;
      if (b4.s_stb && b4.s_rdy) begin
        for (int k = 0; k < 4; k++) q.push_back(byte_at(b4.s_dat, k, 4));
        words_in++;
      end
      if (b4.m_stb && b4.m_rdy) begin
        if (q.size() == 0) begin
          fail("sb_extra_byte", bytes_out + 1, words_in * 4);
        end else begin
          exp_b = q.pop_front();
          chk($sformatf("sb_byte%0d", bytes_out), b4.m_dat, exp_b);
        end
        bytes_out++;
      end
      prev_stall = b4.m_stb && !b4.m_rdy;
      prev_dat   = b4.m_dat;
      cyc++;
    end
    if (cyc >= 30000) fail("sb_timeout", cyc, 30000);
    chk("sb_byte_count", bytes_out, 32'd4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
